// File: rtl/udp_rx_arbiter.sv
// udp_rx_arbiter: frame-atomic round-robin arbiter sharing one udp_main parser between RX byte ports.
// Define UDP_ARB_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYCLES mid-stream.
module udp_rx_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int TIMEOUT_CYCLES = 2048,
   localparam int PW = $clog2(NUM_PORTS)
) (
   input  logic                   main_clk,
   input  logic                   main_rst_n,
   input  logic [NUM_PORTS-1:0]   req_valid,
   input  logic [NUM_PORTS*8-1:0] req_byte,
   input  logic [NUM_PORTS-1:0]   req_last,
   output logic [NUM_PORTS-1:0]   req_ready,
   output logic [7:0]             eth_byte,
   output logic                   input_ready,
   output logic                   parser_rst,
   input  logic                   valid_ip,
   input  logic                   valid_udp,
   output logic [PW-1:0]          grant_id,
   output logic                   busy,
   output logic                   frame_done,
   output logic [PW-1:0]          frame_port,
   output logic                   frame_ip,
   output logic                   frame_udp,
   output logic                   frame_abort
);
   typedef enum logic [2:0] {IDLE, PRST, STREAM, DRAIN, DONE} state_t;
   state_t state, nxt;
   logic [PW-1:0] rr_ptr, pick, port_q;
   logic hit, beat, drn, ip_q, udp_q, tmo, ab, ab_q;
   assign req_ready = (state == STREAM) ? NUM_PORTS'(1) << grant_id : '0;
   assign beat = (state == STREAM) & req_valid[grant_id];
   assign busy = state != IDLE;
   // status is live during DONE so the parser flags are sampled in that cycle, then held
   assign frame_done = state == DONE;
   assign frame_port = frame_done ? grant_id : port_q;
   assign frame_ip = frame_done ? valid_ip & ~ab : ip_q;
   assign frame_udp = frame_done ? valid_udp & ~ab : udp_q;
   assign frame_abort = frame_done ? ab : ab_q;
   always_comb begin
      hit = 1'b0;
      pick = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         if (!hit && req_valid[(int'(rr_ptr) + i) % NUM_PORTS]) begin
            hit = 1'b1;
            pick = PW'((int'(rr_ptr) + i) % NUM_PORTS);
         end
   end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = hit ? PRST : IDLE;
         PRST:    nxt = STREAM;
         STREAM:  nxt = (beat && req_last[grant_id]) ? DRAIN : (tmo ? DONE : STREAM);
         DRAIN:   nxt = drn ? DONE : DRAIN;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         state <= IDLE;
         grant_id <= '0;
         rr_ptr <= '0;
         parser_rst <= 1'b1;
         eth_byte <= '0;
         input_ready <= 1'b0;
         drn <= 1'b0;
         port_q <= '0;
         ip_q <= 1'b0;
         udp_q <= 1'b0;
      end else begin
         state <= nxt;
         parser_rst <= nxt == PRST;
         input_ready <= beat;
         drn <= state == DRAIN && !drn;
         if (beat) eth_byte <= req_byte[8*grant_id +: 8];
         if (state == IDLE && hit) grant_id <= pick;
         if (state == DONE) begin
            rr_ptr <= (int'(grant_id) == NUM_PORTS - 1) ? '0 : grant_id + 1'b1;
            port_q <= grant_id;
            ip_q <= frame_ip;
            udp_q <= frame_udp;
         end
      end
   end
`ifdef UDP_ARB_TIMEOUT_EN
   logic [15:0] timer;
   assign tmo = state == STREAM && !beat && timer == 16'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         timer <= '0;
         ab <= 1'b0;
         ab_q <= 1'b0;
      end else begin
         timer <= (state != STREAM || beat) ? '0 : timer + 1'b1;
         ab <= tmo;
         if (state == DONE) ab_q <= ab;
      end
   end
`else
   assign tmo = 1'b0;
   assign ab = 1'b0;
   assign ab_q = 1'b0;
`endif
endmodule

// File: tb/tb_udp_rx_arbiter.sv
// tb_udp_rx_arbiter: directed bench with per-port byte sources and a minimal udp_main flag model.
module tb_udp_rx_arbiter;
   localparam int NP = 4;
   logic main_clk = 1'b0, main_rst_n = 1'b0;
   logic [NP-1:0] req_valid = '0, req_last = '0, req_ready;
   logic [NP*8-1:0] req_byte = '0;
   logic [7:0] eth_byte;
   logic input_ready, parser_rst, valid_ip = 1'b0, valid_udp = 1'b0;
   logic [1:0] grant_id, frame_port;
   logic busy, frame_done, frame_ip, frame_udp, frame_abort;
   int errors = 0, checks = 0;
   logic [7:0] mem [NP][64];
   int len [NP], nfr [NP], pos [NP], stall [NP];
   int cyc = 0, serr = 0, ircnt = 0, dcyc = 0, lastbeat = 0;
   logic [NP-1:0] lbt = '0;
   logic pend = 1'b0, prev_rdy = 1'b0, dabort, dip, dudp;
   logic [7:0] pbyte = '0;
   logic prh [8192];
   int gq[$], dq[$], riseq[$], lbq[$];
   int pcnt = 0;
   logic [7:0] prev = '0;

   always #5 main_clk = ~main_clk;

   // parser stand-in: IPv4 ethertype at bytes 20/21, UDP protocol at byte 31
   always @(posedge main_clk) begin
      if (parser_rst) begin
         pcnt <= 0;
         valid_ip <= 1'b0;
         valid_udp <= 1'b0;
      end else if (input_ready) begin
         pcnt <= pcnt + 1;
         prev <= eth_byte;
         if (pcnt == 21 && prev == 8'h08 && eth_byte == 8'h00) valid_ip <= 1'b1;
         if (pcnt == 31 && valid_ip && eth_byte == 8'h11) valid_udp <= 1'b1;
      end
   end

   udp_rx_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(16)) dut (
      .main_clk(main_clk), .main_rst_n(main_rst_n),
      .req_valid(req_valid), .req_byte(req_byte), .req_last(req_last), .req_ready(req_ready),
      .eth_byte(eth_byte), .input_ready(input_ready), .parser_rst(parser_rst),
      .valid_ip(valid_ip), .valid_udp(valid_udp), .grant_id(grant_id), .busy(busy),
      .frame_done(frame_done), .frame_port(frame_port), .frame_ip(frame_ip),
      .frame_udp(frame_udp), .frame_abort(frame_abort)
   );

   task automatic step();
      logic [NP-1:0] bt;
      @(negedge main_clk);
      cyc++;
      for (int p = 0; p < NP; p++)
         if (lbt[p]) begin
            if (pos[p] == len[p] - 1) begin
               pos[p] = 0;
               nfr[p]--;
            end else pos[p]++;
         end
      for (int p = 0; p < NP; p++) begin
         req_valid[p] = nfr[p] > 0 && pos[p] != stall[p];
         req_byte[8*p +: 8] = mem[p][pos[p]];
         req_last[p] = pos[p] == len[p] - 1;
      end
      if (input_ready !== pend || (pend && eth_byte !== pbyte)) serr++;
      if ($countones(req_ready) > 1) serr++;
      if (input_ready === 1'b1) ircnt++;
      if (frame_done === 1'b1) begin
         dq.push_back(int'(frame_port));
         dcyc = cyc;
         dabort = frame_abort;
         dip = frame_ip;
         dudp = frame_udp;
      end
      if (req_ready != '0 && !prev_rdy) riseq.push_back(cyc);
      prev_rdy = req_ready != '0;
      prh[cyc % 8192] = parser_rst;
      bt = req_valid & req_ready;
      lbt = bt;
      pend = bt != '0;
      for (int p = 0; p < NP; p++)
         if (bt[p]) begin
            pbyte = mem[p][pos[p]];
            lastbeat = cyc;
            if (pos[p] == 0) gq.push_back(p);
            if (req_last[p]) lbq.push_back(cyc);
         end
   endtask

   task automatic set_frame(input int p, input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) mem[p][i] = base + 8'(i);
      len[p] = n;
      pos[p] = 0;
      stall[p] = -1;
   endtask

   task automatic load_hdr(input int p);
      logic [7:0] h [42];
      h = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
            8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
            8'h08, 8'h00,
            8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
            8'h00, 8'h00, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'h02};
      for (int i = 0; i < 42; i++) mem[p][i] = h[i];
      len[p] = 42;
      pos[p] = 0;
      stall[p] = -1;
   endtask

   task automatic clear_obs();
      serr = 0;
      ircnt = 0;
      gq.delete();
      dq.delete();
      riseq.delete();
      lbq.delete();
   endtask

   task automatic do_reset();
      main_rst_n = 1'b0;
      step();
      main_rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      for (int p = 0; p < NP; p++) begin
         set_frame(p, 3, 8'(16 * (p + 1)));
         nfr[p] = 1;
      end
      main_rst_n = 1'b0;
      step();
      step();
      checks++;
      if (parser_rst !== 1'b1) begin errors++; $display("FAIL reset_parser_rst: got %b want 1", parser_rst); end
      checks++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000 (req_valid=%b)", req_ready, req_valid); end
      checks++;
      if ({eth_byte, input_ready, grant_id, busy, frame_done, frame_port, frame_ip, frame_udp, frame_abort} !== 18'd0) begin
         errors++;
         $display("FAIL reset_outputs: got eth=%h ir=%b gid=%0d busy=%b done=%b port=%0d ip=%b udp=%b ab=%b want all 0",
                  eth_byte, input_ready, grant_id, busy, frame_done, frame_port, frame_ip, frame_udp, frame_abort);
      end
      for (int p = 0; p < NP; p++) nfr[p] = 0;
      step();
      main_rst_n = 1'b1;
      step();
      step();
      checks++;
      if (parser_rst !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got parser_rst=%b busy=%b want 0 0", parser_rst, busy); end
   endtask

   task automatic test_single_frame();
      int c0;
      clear_obs();
      load_hdr(0);
      nfr[0] = 1;
      c0 = cyc + 1;
      for (int i = 0; i < 200 && dq.size() < 1; i++) step();
      checks++;
      if (riseq.size() < 1 || riseq[0] - c0 != 2) begin errors++; $display("FAIL grant_latency: got %p (start %0d) want start+2", riseq, c0); end
      checks++;
      if (prh[(c0 + 1) % 8192] !== 1'b1 || prh[(c0 + 2) % 8192] !== 1'b0) begin
         errors++; $display("FAIL prst_pulse: got %b%b want 10", prh[(c0 + 1) % 8192], prh[(c0 + 2) % 8192]);
      end
      checks++;
      if (ircnt != 42) begin errors++; $display("FAIL single_byte_count: got %0d want 42", ircnt); end
      checks++;
      if (dq.size() != 1 || lbq.size() < 1 || dcyc - lbq[0] != 3) begin errors++; $display("FAIL done_latency: got done=%p last=%p want last+3", dq, lbq); end
      checks++;
      if (dq.size() != 1 || dq[0] != 0) begin errors++; $display("FAIL single_port: got %p want '{0}", dq); end
      checks++;
      if (dip !== 1'b1 || dudp !== 1'b1 || dabort !== 1'b0) begin errors++; $display("FAIL single_flags: got ip=%b udp=%b ab=%b want 1 1 0", dip, dudp, dabort); end
      checks++;
      if (serr != 0) begin errors++; $display("FAIL single_stream: got %0d byte errors want 0", serr); end
   endtask

   task automatic test_round_robin();
      do_reset();
      clear_obs();
      for (int p = 0; p < NP; p++) begin
         set_frame(p, 3, 8'(16 * (p + 1)));
         nfr[p] = 1;
      end
      nfr[0] = 2;
      for (int i = 0; i < 300 && dq.size() < 5; i++) step();
      checks++;
      if (gq.size() != 5 || gq[0] != 0 || gq[1] != 1 || gq[2] != 2 || gq[3] != 3 || gq[4] != 0) begin
         errors++; $display("FAIL rr_grant_order: got %p want '{0,1,2,3,0}", gq);
      end
      checks++;
      if (dq.size() != 5 || dq[0] != 0 || dq[1] != 1 || dq[2] != 2 || dq[3] != 3 || dq[4] != 0) begin
         errors++; $display("FAIL rr_done_order: got %p want '{0,1,2,3,0}", dq);
      end
      checks++;
      if (ircnt != 15) begin errors++; $display("FAIL rr_byte_count: got %0d want 15", ircnt); end
      checks++;
      if (serr != 0) begin errors++; $display("FAIL rr_stream: got %0d byte/onehot errors want 0", serr); end
   endtask

   task automatic test_back_to_back();
      clear_obs();
      set_frame(2, 3, 8'hA0);
      nfr[2] = 2;
      for (int i = 0; i < 200 && dq.size() < 2; i++) step();
      checks++;
      if (dq.size() != 2 || dq[0] != 2 || dq[1] != 2) begin errors++; $display("FAIL b2b_ports: got %p want '{2,2}", dq); end
      checks++;
      if (riseq.size() < 2 || lbq.size() < 1 || riseq[1] - lbq[0] != 6) begin
         errors++; $display("FAIL b2b_gap: got ready=%p last=%p want last+6", riseq, lbq);
      end
      step();
      step();
      step();
      checks++;
      if (frame_done !== 1'b0 || frame_port !== 2'd2) begin errors++; $display("FAIL status_hold: got done=%b port=%0d want 0 2", frame_done, frame_port); end
   endtask

   task automatic test_no_preempt();
      bit armed = 0;
      clear_obs();
      set_frame(2, 6, 8'hB0);
      nfr[2] = 1;
      for (int i = 0; i < 300 && dq.size() < 3; i++) begin
         step();
         if (!armed && pos[2] == 2) begin
            set_frame(0, 3, 8'hC0);
            set_frame(1, 3, 8'hD0);
            nfr[0] = 1;
            nfr[1] = 1;
            armed = 1;
         end
      end
      checks++;
      if (dq.size() != 3 || dq[0] != 2 || dq[1] != 0 || dq[2] != 1) begin errors++; $display("FAIL nopreempt_order: got %p want '{2,0,1}", dq); end
      checks++;
      if (riseq.size() < 1 || lbq.size() < 1 || lbq[0] - riseq[0] != 5) begin
         errors++; $display("FAIL nopreempt_contig: got ready=%p last=%p want first+5", riseq, lbq);
      end
      checks++;
      if (serr != 0) begin errors++; $display("FAIL nopreempt_stream: got %0d errors want 0", serr); end
   endtask

   task automatic test_timeout();
      clear_obs();
      load_hdr(1);
      stall[1] = 30;
      nfr[1] = 1;
`ifdef UDP_ARB_TIMEOUT_EN
      for (int i = 0; i < 200 && dq.size() < 1; i++) step();
      checks++;
      if (dq.size() != 1 || dq[0] != 1 || dabort !== 1'b1) begin errors++; $display("FAIL tmo_abort: got done=%p ab=%b want '{1} 1", dq, dabort); end
      checks++;
      if (dcyc - lastbeat != 17) begin errors++; $display("FAIL tmo_latency: got %0d want 17", dcyc - lastbeat); end
      checks++;
      if (dip !== 1'b0 || dudp !== 1'b0) begin errors++; $display("FAIL tmo_flags: got ip=%b udp=%b want 0 0", dip, dudp); end
      step();
      checks++;
      if (dut.rr_ptr !== 2'd2) begin errors++; $display("FAIL tmo_rr_ptr: got %0d want 2", dut.rr_ptr); end
      stall[1] = -1;
      for (int i = 0; i < 200 && dq.size() < 2; i++) step();
      checks++;
      if (dq.size() != 2 || dq[1] != 1 || dabort !== 1'b0) begin errors++; $display("FAIL tmo_rest_frame: got done=%p ab=%b want '{1,1} 0", dq, dabort); end
`else
      for (int i = 0; i < 80; i++) step();
      checks++;
      if (dq.size() != 0 || busy !== 1'b1 || frame_abort !== 1'b0) begin
         errors++; $display("FAIL stall_wait: got done=%p busy=%b ab=%b want none 1 0", dq, busy, frame_abort);
      end
      stall[1] = -1;
      for (int i = 0; i < 200 && dq.size() < 1; i++) step();
      checks++;
      if (dq.size() != 1 || dq[0] != 1 || dabort !== 1'b0 || dip !== 1'b1) begin
         errors++; $display("FAIL stall_resume: got done=%p ab=%b ip=%b want '{1} 0 1", dq, dabort, dip);
      end
      step();
      checks++;
      if (dut.rr_ptr !== 2'd2) begin errors++; $display("FAIL stall_rr_ptr: got %0d want 2", dut.rr_ptr); end
`endif
      checks++;
      if (serr != 0) begin errors++; $display("FAIL timeout_stream: got %0d errors want 0", serr); end
   endtask

   task automatic test_reset_mid_frame();
      int c0;
      clear_obs();
      set_frame(3, 10, 8'h70);
      nfr[3] = 1;
      for (int i = 0; i < 40 && pos[3] != 4; i++) step();
      dq.delete();
      #2 main_rst_n = 1'b0;
      lbt = '0;
      pend = 1'b0;
      #1;
      checks++;
      if (parser_rst !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_async: got parser_rst=%b req_ready=%b want 1 0000", parser_rst, req_ready); end
      checks++;
      if ({eth_byte, input_ready, grant_id, busy, frame_done, frame_port, frame_ip, frame_udp, frame_abort} !== 18'd0) begin
         errors++; $display("FAIL midrst_outputs: got eth=%h ir=%b gid=%0d busy=%b port=%0d want all 0", eth_byte, input_ready, grant_id, busy, frame_port);
      end
      checks++;
      if (dut.rr_ptr !== 2'd0) begin errors++; $display("FAIL midrst_rr_ptr: got %0d want 0", dut.rr_ptr); end
      nfr[3] = 0;
      step();
      step();
      main_rst_n = 1'b1;
      step();
      step();
      checks++;
      if (dq.size() != 0) begin errors++; $display("FAIL midrst_no_done: got %p want none", dq); end
      clear_obs();
      nfr[3] = 1;
      set_frame(1, 4, 8'h80);
      nfr[1] = 1;
      c0 = cyc + 1;
      for (int i = 0; i < 200 && dq.size() < 2; i++) step();
      checks++;
      if (dq.size() != 2 || dq[0] != 1 || dq[1] != 3) begin errors++; $display("FAIL midrst_regrant: got %p want '{1,3}", dq); end
      checks++;
      if (riseq.size() < 1 || riseq[0] - c0 != 2 || prh[(c0 + 1) % 8192] !== 1'b1 || prh[c0 % 8192] !== 1'b0) begin
         errors++; $display("FAIL midrst_prst: got ready=%p prst=%b%b want start+2 01", riseq, prh[c0 % 8192], prh[(c0 + 1) % 8192]);
      end
      checks++;
      if (serr != 0) begin errors++; $display("FAIL midrst_stream: got %0d errors want 0", serr); end
   endtask

   initial begin
      for (int p = 0; p < NP; p++) begin
         nfr[p] = 0;
         pos[p] = 0;
         len[p] = 1;
         stall[p] = -1;
      end
      test_reset();
      test_single_frame();
      test_round_robin();
      test_back_to_back();
      test_no_preempt();
      test_timeout();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit want completion");
      $fatal(1, "time limit");
   end
endmodule

// File: doc/udp_rx_arbiter.md
# udp_rx_arbiter

Frame-atomic round-robin arbiter and sequencer that shares one `udp_main` header parser between `NUM_PORTS` Ethernet RX byte streams. It grants one port per frame and forwards that port's bytes to the parser. It pulses the parser's reset before each frame and samples the parser's `valid_ip`/`valid_udp` flags after the frame has drained. It then reports a per-frame status word. It sits between the MAC-side RX byte sources and the parser.

## Interface
- `NUM_PORTS`, 4: number of requesting RX ports; legal range 2..8.
- `TIMEOUT_CYCLES`, 2048: idle cycles mid-frame before the frame is aborted; legal range 2..65535.
- `PW`, `$clog2(NUM_PORTS)`: port-id width (derived, not overridable).

Ports:
- `main_clk` in 1: single clock.
- `main_rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_PORTS`: per-port byte valid.
- `req_byte` in `NUM_PORTS*8`: per-port byte; port k occupies bits [8k+7:8k].
- `req_last` in `NUM_PORTS`: per-port last byte of frame, qualified by `req_valid`.
- `req_ready` out `NUM_PORTS`: per-port accept.
- `eth_byte` out 8: byte to the parser.
- `input_ready` out 1: parser byte strobe.
- `parser_rst` out 1: active-high reset to the parser.
- `valid_ip` in 1: parser flag.
- `valid_udp` in 1: parser flag.
- `grant_id` out `PW`: currently or last granted port.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle status strobe.
- `frame_port` out `PW`: port of the completed frame.
- `frame_ip` out 1: sampled `valid_ip`.
- `frame_udp` out 1: sampled `valid_udp`.
- `frame_abort` out 1: frame ended by timeout.

## Operation
- **States:** IDLE, PRST, STREAM, DRAIN, DONE.
- **Reset values:**
  - `parser_rst`=1.
  - All other outputs 0.
  - Round-robin pointer `rr_ptr`=0, timer 0, state IDLE.
- **IDLE:**
  - `parser_rst`=0.
  - If any `req_valid` is high, grant the first port k with `req_valid[k]`=1, searching from `rr_ptr` upward and wrapping modulo `NUM_PORTS`.
  - Register `grant_id`=k and go to PRST.
- **PRST:** `parser_rst`=1 for exactly one cycle, then STREAM.
- **STREAM:**
  - `req_ready[grant_id]`=1; all other `req_ready` bits are 0.
  - A beat is `req_valid[g] & req_ready[g]`.
  - Each beat registers `eth_byte` and pulses `input_ready` on the next cycle.
  - A beat with `req_last`=1 goes to DRAIN.
  - Every beat clears the idle timer; a cycle with no beat increments it.
- **DRAIN:** hold for 2 cycles so the final byte reaches the parser and its flags settle, then DONE.
- **DONE (one cycle):**
  - Pulse `frame_done`.
  - Set `frame_port`=`grant_id`, `frame_ip`=`valid_ip`, `frame_udp`=`valid_udp`, `frame_abort`=0.
  - Set `rr_ptr`=(`grant_id`+1) mod `NUM_PORTS`.
  - Go to IDLE.
- **Status hold:** `frame_*` status outputs hold their values until the next DONE.
- **Non-granted ports:** requests from ports that are not granted are stalled, never dropped.
- **Grant is frame-atomic:** a higher-priority request never preempts the current frame.

## Timing
- Byte latency: source beat to `input_ready`/`eth_byte` is 1 cycle.
- Grant latency: `req_valid` rising in IDLE gives `req_ready` 2 cycles later (IDLE→PRST→STREAM).
- Frame turnaround: the `req_last` beat leads to `frame_done` 3 cycles later. The earliest next grant is in the cycle after DONE.
- Back-to-back frames on a single port cost 5 idle cycles between the last beat and the next `req_ready`.
- Timer and beat in the same cycle: the beat wins and the timer clears.
- `main_rst_n` asserted mid-frame:
  - Immediate return to reset values with `parser_rst`=1.
  - No `frame_done` is produced.
  - The partial frame is lost.
- `rr_ptr` wrap-around: a grant to port `NUM_PORTS-1` sets `rr_ptr`=0.

## Configuration
- **`UDP_ARB_TIMEOUT_EN` defined:**
  - In STREAM, when the timer reaches `TIMEOUT_CYCLES-1` with no beat, go to DONE directly.
  - DONE then sets `frame_abort`=1 and `frame_ip`=`frame_udp`=0, and advances `rr_ptr` as normal.
  - Bytes the source presents later, up to its `req_last`, are arbitrated as a new frame.
- **`UDP_ARB_TIMEOUT_EN` undefined:**
  - No timer logic; STREAM waits indefinitely.
  - `frame_abort` is tied to 0.

## Test plan
- Reset with `main_rst_n`=0:
  - `parser_rst`=1.
  - All other outputs 0.
  - `req_ready`=0 for any `req_valid`.
- Port 0, single frame of 7×0x55, 0xD5, then 14+20 header bytes with ethertype 0x0800; parser model raises `valid_ip`:
  - `input_ready` count equals the byte count.
  - `frame_done` 3 cycles after last, with `frame_port`=0, `frame_ip`=1, `frame_abort`=0.
- All 4 ports requesting continuously with 3-byte frames:
  - Grant order is 0,1,2,3,0.
  - `req_ready` is never high for two ports at once.
  - No byte from a non-granted port reaches `eth_byte`.
- Port 2 granted while port 1 raises `req_valid` mid-frame:
  - Port 2 completes its frame uninterrupted.
  - Next grant is 3 if requesting, else 0, else 1.
- `UDP_ARB_TIMEOUT_EN` with `TIMEOUT_CYCLES`=16; port 1 stalls after 5 bytes:
  - `frame_done` with `frame_abort`=1 and `frame_port`=1.
  - `rr_ptr`=2.
- `main_rst_n` pulsed low during STREAM:
  - Outputs go to reset values asynchronously.
  - After release, IDLE regrants from `rr_ptr`=0 with a fresh PRST pulse.
